// File: rtl/seq_restoring_divider_pkg.sv
// -----------------------------------------------------------------------------
// seq_restoring_divider_pkg
// Shared definitions for the sequential restoring divider:
//   - FSM state encoding (S_IDLE, S_RUN, S_DONE)
//   - default operand width DIV_W
//   - iteration counter width helper
// Optional feature macro used by the divider: DIV_ZERO_CHECK_EN
// -----------------------------------------------------------------------------
package seq_restoring_divider_pkg;

    localparam int DIV_W = 16;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    // Counter must hold 0 .. 2W-1; one extra bit keeps headroom for any W.
    function automatic int cnt_width(input int w);
        return $clog2(2 * w) + 1;
    endfunction

endpackage

// File: rtl/seq_restoring_divider_div_step.sv
// -----------------------------------------------------------------------------
// div_step
// One combinational restoring-division iteration.
// Ports:
//   rem_i      W+1  current partial remainder
//   bit_i      1    next dividend bit shifted in
//   divisor_i  W    divisor
//   rem_o      W+1  next partial remainder
//   q_o        1    quotient bit produced by this step
// -----------------------------------------------------------------------------
module div_step #(
    parameter int W = 16
) (
    input  logic [W:0]   rem_i,
    input  logic         bit_i,
    input  logic [W-1:0] divisor_i,
    output logic [W:0]   rem_o,
    output logic         q_o
);

    logic [W:0] shifted_s;
    logic [W:0] diff_s;

    // Shift in the next dividend bit, then subtract the divisor if it fits.
    always_comb begin
        // The previous remainder is always < divisor, so its top bit is zero and may be dropped.
        shifted_s = {rem_i[W-1:0], bit_i};
        diff_s    = shifted_s - {1'b0, divisor_i};
        if (shifted_s >= {1'b0, divisor_i}) begin
            rem_o = diff_s;
            q_o   = 1'b1;
        end else begin
            rem_o = shifted_s;
            q_o   = 1'b0;
        end
    end

endmodule

// File: rtl/seq_restoring_divider.sv
// -----------------------------------------------------------------------------
// seq_restoring_divider
// Multi-cycle unsigned restoring divider: 2W-bit dividend / W-bit divisor,
// one quotient bit per clock, start/busy/done handshake.
// Ports:
//   clk        clock, rising edge
//   rst        asynchronous active-high reset
//   start      request, sampled only when not busy
//   dividend   2W  latched on an accepted start
//   divisor    W   latched on an accepted start
//   busy       high while iterating
//   done       one-cycle pulse, results valid from this cycle
//   quotient   2W  result, held until the next run completes
//   remainder  W   result, held as quotient
//   div_zero   divide-by-zero flag
// Configuration macro: DIV_ZERO_CHECK_EN
//   defined   -> zero divisor exits after one step with quotient all ones,
//                remainder 0 and div_zero set
//   undefined -> zero divisor runs the normal 2W steps, div_zero tied 0
// -----------------------------------------------------------------------------
module seq_restoring_divider
    import seq_restoring_divider_pkg::*;
#(
    parameter int W = DIV_W
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           start,
    input  logic [2*W-1:0] dividend,
    input  logic [W-1:0]   divisor,
    output logic           busy,
    output logic           done,
    output logic [2*W-1:0] quotient,
    output logic [W-1:0]   remainder,
    output logic           div_zero
);

    localparam int CW = cnt_width(W);
    localparam logic [CW-1:0] LAST_CNT = CW'(2 * W - 1);

    logic [1:0]     state_q, state_d;
    logic [CW-1:0]  cnt_q,   cnt_d;
    logic [W:0]     rem_q,   rem_d;
    logic [2*W-1:0] dq_q,    dq_d;    // dividend shifts out the top, quotient bits enter at the bottom
    logic [W-1:0]   dvs_q,   dvs_d;
    logic [2*W-1:0] quo_q,   quo_d;
    logic [W-1:0]   rmd_q,   rmd_d;
    logic           busy_q,  busy_d;
    logic           done_q,  done_d;

    logic [W:0]     step_rem_s;
    logic           step_q_s;

`ifdef DIV_ZERO_CHECK_EN
    logic           dz_q, dz_d;
`endif

    div_step #(.W(W)) u_step (
        .rem_i     (rem_q),
        .bit_i     (dq_q[2*W-1]),
        .divisor_i (dvs_q),
        .rem_o     (step_rem_s),
        .q_o       (step_q_s)
    );

    // Next-state logic for the FSM, iteration datapath and result registers.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rem_d   = rem_q;
        dq_d    = dq_q;
        dvs_d   = dvs_q;
        quo_d   = quo_q;
        rmd_d   = rmd_q;
        busy_d  = 1'b0;
        done_d  = 1'b0;
`ifdef DIV_ZERO_CHECK_EN
        dz_d    = dz_q;
`endif
        case (state_q)
            S_IDLE, S_DONE: begin
                // A start in DONE wins over the return to IDLE.
                if (start) begin
                    state_d = S_RUN;
                    cnt_d   = {CW{1'b0}};
                    rem_d   = {(W+1){1'b0}};
                    dq_d    = dividend;
                    dvs_d   = divisor;
                    busy_d  = 1'b1;
`ifdef DIV_ZERO_CHECK_EN
                    dz_d    = 1'b0;
`endif
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_RUN: begin
`ifdef DIV_ZERO_CHECK_EN
                if (dvs_q == {W{1'b0}}) begin
                    state_d = S_DONE;
                    done_d  = 1'b1;
                    quo_d   = {(2*W){1'b1}};
                    rmd_d   = {W{1'b0}};
                    dz_d    = 1'b1;
                end else begin
`endif
                    rem_d = step_rem_s;
                    dq_d  = {dq_q[2*W-2:0], step_q_s};
                    if (cnt_q == LAST_CNT) begin
                        state_d = S_DONE;
                        done_d  = 1'b1;
                        quo_d   = {dq_q[2*W-2:0], step_q_s};
                        rmd_d   = step_rem_s[W-1:0];
                    end else begin
                        cnt_d  = cnt_q + CW'(1);
                        busy_d = 1'b1;
                    end
`ifdef DIV_ZERO_CHECK_EN
                end
`endif
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and datapath registers with asynchronous reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= {CW{1'b0}};
            rem_q   <= {(W+1){1'b0}};
            dq_q    <= {(2*W){1'b0}};
            dvs_q   <= {W{1'b0}};
            quo_q   <= {(2*W){1'b0}};
            rmd_q   <= {W{1'b0}};
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rem_q   <= rem_d;
            dq_q    <= dq_d;
            dvs_q   <= dvs_d;
            quo_q   <= quo_d;
            rmd_q   <= rmd_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

`ifdef DIV_ZERO_CHECK_EN
    // Divide-by-zero flag register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dz_q <= 1'b0;
        end else begin
            dz_q <= dz_d;
        end
    end
    assign div_zero = dz_q;
`else
    assign div_zero = 1'b0;
`endif

    assign busy      = busy_q;
    assign done      = done_q;
    assign quotient  = quo_q;
    assign remainder = rmd_q;

endmodule

// File: tb/tb_seq_restoring_divider.sv
// -----------------------------------------------------------------------------
// tb_seq_restoring_divider
// Self-checking bench: directed cases, start-in-RUN, back-to-back start,
// reset mid-run and 1000 random operand pairs against an arithmetic model.
// -----------------------------------------------------------------------------
module tb_seq_restoring_divider;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic [31:0] dividend = 32'd0;
    logic [15:0] divisor = 16'd0;
    logic        busy;
    logic        done;
    logic [31:0] quotient;
    logic [15:0] remainder;
    logic        div_zero;

    int n_tests = 0;
    int n_fail  = 0;

    seq_restoring_divider #(.W(16)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .dividend  (dividend),
        .divisor   (divisor),
        .busy      (busy),
        .done      (done),
        .quotient  (quotient),
        .remainder (remainder),
        .div_zero  (div_zero)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference: plain arithmetic, with the documented divide-by-zero result.
    task automatic model(input logic [31:0] a, input logic [15:0] b,
                         output logic [31:0] q, output logic [15:0] r,
                         output logic dz, output int lat);
        if (b == 16'd0) begin
            q = 32'hFFFF_FFFF;
`ifdef DIV_ZERO_CHECK_EN
            r   = 16'd0;
            dz  = 1'b1;
            lat = 1;
`else
            r   = a[15:0];
            dz  = 1'b0;
            lat = 32;
`endif
        end else begin
            q   = a / {16'd0, b};
            r   = 16'(a % {16'd0, b});
            dz  = 1'b0;
            lat = 32;
        end
    endtask

    // Present operands with start; returns 1 time unit after the accepting edge.
    task automatic start_div(input logic [31:0] a, input logic [15:0] b);
        dividend = a;
        divisor  = b;
        start    = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        check_val("busy_after_accept", {63'd0, busy}, 64'd1);
    endtask

    // Wait for done, optionally re-pulsing start with junk operands at edge 'poke'.
    task automatic wait_check(input string tag, input logic [31:0] a, input logic [15:0] b, input int poke);
        logic [31:0] eq;
        logic [15:0] er;
        logic        edz;
        int          elat;
        int          cyc;
        logic [31:0] q0;
        model(a, b, eq, er, edz, elat);
        q0  = quotient;
        cyc = 0;
        do begin
            if (poke != 0 && cyc + 1 == poke) begin
                start    = 1'b1;
                dividend = $urandom;
                divisor  = 16'($urandom_range(1, 65535));
            end else begin
                start = 1'b0;
            end
            @(posedge clk);
            #1;
            cyc++;
            if (cyc == 16 && !done) check_val({tag, "_hold_q"}, {32'd0, quotient}, {32'd0, q0});
        end while (!done && cyc < 100);
        start = 1'b0;
        check_val({tag, "_latency"}, 64'(cyc), 64'(elat));
        check_val({tag, "_quotient"}, {32'd0, quotient}, {32'd0, eq});
        check_val({tag, "_remainder"}, {48'd0, remainder}, {48'd0, er});
        check_val({tag, "_div_zero"}, {63'd0, div_zero}, {63'd0, edz});
    endtask

    logic [31:0] d_a [6] = '{32'd2, 32'd945, 32'd1000, 32'hFFFE0001, 32'hFFFFFFFF, 32'h1234ABCD};
    logic [15:0] d_b [6] = '{16'd1, 16'd35, 16'd7, 16'hFFFF, 16'd1, 16'd0};

    initial begin
        int done_seen;
        logic [31:0] ra;
        logic [15:0] rb;

        // Reset state
        #2 rst = 1'b1;
        #1;
        check_val("rst_busy", {63'd0, busy}, 64'd0);
        check_val("rst_done", {63'd0, done}, 64'd0);
        check_val("rst_quotient", {32'd0, quotient}, 64'd0);
        check_val("rst_remainder", {48'd0, remainder}, 64'd0);
        check_val("rst_div_zero", {63'd0, div_zero}, 64'd0);
        @(negedge clk);
        rst = 1'b0;

        // Directed cases, each followed by a check that done is a single pulse
        for (int i = 0; i < 6; i++) begin
            start_div(d_a[i], d_b[i]);
            wait_check("directed", d_a[i], d_b[i], 0);
            @(posedge clk);
            #1;
            check_val("done_pulse", {63'd0, done}, 64'd0);
        end

        // Start pulsed during RUN is ignored
        start_div(32'd1000, 16'd7);
        wait_check("ignore_start", 32'd1000, 16'd7, 10);

        // Back-to-back start in the DONE cycle
        start_div(32'd945, 16'd35);
        wait_check("back_to_back", 32'd945, 16'd35, 0);

        // Reset in the middle of RUN
        start_div(32'hDEADBEEF, 16'd1234);
        repeat (14) @(posedge clk);
        #2 rst = 1'b1;
        #1;
        check_val("midrst_busy", {63'd0, busy}, 64'd0);
        check_val("midrst_done", {63'd0, done}, 64'd0);
        check_val("midrst_quotient", {32'd0, quotient}, 64'd0);
        check_val("midrst_remainder", {48'd0, remainder}, 64'd0);
        @(negedge clk);
        rst = 1'b0;
        done_seen = 0;
        repeat (40) begin
            @(posedge clk);
            #1;
            if (done) done_seen++;
        end
        check_val("midrst_no_done", 64'(done_seen), 64'd0);
        start_div(32'd100000, 16'd300);
        wait_check("after_rst", 32'd100000, 16'd300, 0);

        // Random operands, back-to-back
        for (int i = 0; i < 1000; i++) begin
            ra = $urandom;
            if (i % 4 == 0) ra = ra >> $urandom_range(0, 31);
            rb = 16'($urandom_range(1, 65535));
            if (i % 8 == 1) rb = 16'($urandom_range(1, 15));
            start_div(ra, rb);
            wait_check("random", ra, rb, 0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
